nav_heading_fsm: RTL and testbench

Parametrised heading/navigation controller. It accepts straight/left/right/stop commands over a valid/ready handshake. It tracks a heading modulo 2^HEADING_W and a forward-move odometer, and models turn and move durations as multi-cycle busy periods. It sits between the command decoder and the motor sequencer.

---
 rtl/nav_heading_fsm.sv | 157 +++++++++++++++
 tb/tb_nav_heading_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nav_heading_fsm.sv
// nav_heading_fsm: heading/navigation controller between the command decoder
// and the motor sequencer. Commands (straight/left/right/stop) arrive over a
// valid/ready handshake. Turns and moves are modelled as multi-cycle busy
// periods, and their effect lands on the completing edge together with a one-cycle
// done pulse.
// Optional build macro: NAV_ABORT_EN adds abort/abort_ack so that an in-flight
// turn or move can be cancelled.
module nav_heading_fsm #(
  parameter int HEADING_W    = 2,
  parameter int TURN_STEP    = 1,
  parameter int TURN_CYCLES  = 2,
  parameter int MOVE_CYCLES  = 3,
  parameter int ODO_W        = 4,
  parameter int INIT_HEADING = 0
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd,
  output logic                 cmd_ready,
  input  logic                 resume,
  output logic [HEADING_W-1:0] heading,
  output logic [ODO_W-1:0]     odometer,
  output logic                 busy,
  output logic                 halted,
  output logic                 done,
  output logic [1:0]           fsm_state
`ifdef NAV_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 abort_ack
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_MOVE = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [1:0] CMD_STRAIGHT = 2'd0;
  localparam logic [1:0] CMD_LEFT     = 2'd1;
  localparam logic [1:0] CMD_RIGHT    = 2'd2;

  // The counter only has to hold the larger load value (N-1).
  localparam int MAXC  = (TURN_CYCLES > MOVE_CYCLES) ? TURN_CYCLES : MOVE_CYCLES;
  localparam int CNT_W = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CNT_W-1:0]     TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0]     MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [HEADING_W-1:0] STEP      = HEADING_W'(TURN_STEP);
  localparam logic [HEADING_W-1:0] HEAD_INIT = HEADING_W'(INIT_HEADING);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 turn_right, turn_right_nx;
  logic [HEADING_W-1:0] heading_nx;
  logic [ODO_W-1:0]     odo_nx;
  logic                 done_nx;
`ifdef NAV_ABORT_EN
  logic                 ack_nx;
`endif

  assign fsm_state = state;

  // State register plus registered flags. The flags are decoded from the next
  // state, so they change on the same edge as fsm_state.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      turn_right <= 1'b0;
      heading    <= HEAD_INIT;
      odometer   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      cmd_ready  <= 1'b1;
`ifdef NAV_ABORT_EN
      abort_ack  <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      turn_right <= turn_right_nx;
      heading    <= heading_nx;
      odometer   <= odo_nx;
      done       <= done_nx;
      busy       <= (state_nx == S_TURN) || (state_nx == S_MOVE);
      halted     <= (state_nx == S_HALT);
      cmd_ready  <= (state_nx == S_IDLE);
`ifdef NAV_ABORT_EN
      abort_ack  <= ack_nx;
`endif
    end
  end

  // Next-state logic. A turn or move completes when the counter reaches zero,
  // and the heading or odometer is updated on that same edge.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    turn_right_nx = turn_right;
    heading_nx    = heading;
    odo_nx        = odometer;
    done_nx       = 1'b0;
`ifdef NAV_ABORT_EN
    ack_nx        = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          unique case (cmd)
            CMD_STRAIGHT: begin
              state_nx = S_MOVE;
              cnt_nx   = MOVE_LOAD;
            end
            CMD_LEFT, CMD_RIGHT: begin
              state_nx      = S_TURN;
              cnt_nx        = TURN_LOAD;
              turn_right_nx = (cmd == CMD_RIGHT);
            end
            default: state_nx = S_HALT;
          endcase
        end
      end
      S_TURN, S_MOVE: begin
        // Completion has priority over abort on the same edge.
        if (cnt == '0) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
          if (state == S_TURN) begin
            heading_nx = turn_right ? heading + STEP : heading - STEP;
          end else if (odometer != '1) begin
            odo_nx = odometer + 1'b1;
          end
        end
`ifdef NAV_ABORT_EN
        else if (abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          ack_nx   = 1'b1;
        end
`endif
        else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_HALT: begin
        if (resume) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nav_heading_fsm.sv
// Directed testbench for nav_heading_fsm using the default parameters
// (4 headings, turn = 2 cycles, move = 3 cycles, 4-bit odometer).
module tb_nav_heading_fsm;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic       cmd_ready;
  logic       resume = 1'b0;
  logic [1:0] heading;
  logic [3:0] odometer;
  logic       busy, halted, done;
  logic [1:0] fsm_state;
`ifdef NAV_ABORT_EN
  logic       abort = 1'b0;
  logic       abort_ack;
`endif

  int checks = 0;
  int failures = 0;

  nav_heading_fsm dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .resume    (resume),
    .heading   (heading),
    .odometer  (odometer),
    .busy      (busy),
    .halted    (halted),
    .done      (done),
    .fsm_state (fsm_state)
`ifdef NAV_ABORT_EN
    ,
    .abort     (abort),
    .abort_ack (abort_ack)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it through to completion (n = duration).
  task automatic run_cmd(input logic [1:0] c, input int n, input int exp_head,
                         input int exp_odo, input string tag);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_busy_acc"}, 32'(busy), 1);
    chk({tag, "_rdy_acc"}, 32'(cmd_ready), 0);
    for (int i = 1; i < n; i++) begin
      tick();
      chk({tag, "_busy_mid"}, 32'(busy), 1);
      chk({tag, "_done_mid"}, 32'(done), 0);
    end
    tick();
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_head"}, 32'(heading), 32'(exp_head));
    chk({tag, "_odo"}, 32'(odometer), 32'(exp_odo));
    chk({tag, "_state"}, 32'(fsm_state), 0);
    chk({tag, "_rdy"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    // ---- 1. reset ----
    #2 nRESET = 1'b0;
    tick();
    tick();
    chk("rst_head", 32'(heading), 0);
    chk("rst_odo", 32'(odometer), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_state", 32'(fsm_state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_done", 32'(done), 0);
    nRESET = 1'b1;
    tick();
    chk("rel_state", 32'(fsm_state), 0);
    chk("rel_ready", 32'(cmd_ready), 1);

    // ---- 2. four rights wrap the heading ----
    run_cmd(2'd2, 2, 1, 0, "r1");
    run_cmd(2'd2, 2, 2, 0, "r2");
    run_cmd(2'd2, 2, 3, 0, "r3");
    run_cmd(2'd2, 2, 0, 0, "r4");
    tick();
    chk("done_pulse_clr", 32'(done), 0);

    // ---- 3. left from 0 wraps to 3; 16 moves saturate the odometer ----
    run_cmd(2'd1, 2, 3, 0, "l1");
    for (int m = 1; m <= 16; m++)
      run_cmd(2'd0, 3, 3, (m > 15) ? 15 : m, $sformatf("mv%0d", m));

    // ---- async reset mid-move, without a clock edge ----
    cmd_valid = 1'b1;
    cmd = 2'd0;
    tick();
    cmd_valid = 1'b0;
    chk("pre_arst_state", 32'(fsm_state), 2);
    #2 nRESET = 1'b0;
    #1;
    chk("arst_state", 32'(fsm_state), 0);
    chk("arst_head", 32'(heading), 0);
    chk("arst_odo", 32'(odometer), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    tick();
    nRESET = 1'b1;
    tick();
    chk("arst_no_done", 32'(done), 0);

    // ---- 4. cmd_valid held: accepts at edges 0 and 4 only ----
    cmd_valid = 1'b1;
    cmd = 2'd0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 0) chk("hold_acc0", 32'(fsm_state), 2);
      if (e == 3) chk("hold_done1", 32'(done), 1);
      if (e == 4) begin
        chk("hold_acc4", 32'(fsm_state), 2);
        chk("hold_odo1", 32'(odometer), 1);
      end
    end
    cmd_valid = 1'b0;
    chk("hold_done2", 32'(done), 1);
    chk("hold_odo2", 32'(odometer), 2);
    tick();
    tick();
    chk("hold_final_odo", 32'(odometer), 2);
    chk("hold_final_state", 32'(fsm_state), 0);

    // ---- 5. stop / halt / resume ----
    cmd_valid = 1'b1;
    cmd = 2'd3;
    tick();
    cmd = 2'd2;
    chk("halt_state", 32'(fsm_state), 3);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_ready", 32'(cmd_ready), 0);
    tick();
    tick();
    tick();
    cmd_valid = 1'b0;
    chk("halt_ign_head", 32'(heading), 0);
    chk("halt_ign_state", 32'(fsm_state), 3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_state", 32'(fsm_state), 0);
    chk("resume_ready", 32'(cmd_ready), 1);
    chk("resume_halted", 32'(halted), 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_idle_noeff", 32'(fsm_state), 0);

`ifdef NAV_ABORT_EN
    // ---- 6. abort mid-move, then abort on the completing edge ----
    cmd_valid = 1'b1;
    cmd = 2'd0;
    tick();
    cmd_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", 32'(fsm_state), 0);
    chk("abort_ack", 32'(abort_ack), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_odo", 32'(odometer), 2);
    tick();
    chk("abort_ack_clr", 32'(abort_ack), 0);
    cmd_valid = 1'b1;
    cmd = 2'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_late_done", 32'(done), 1);
    chk("abort_late_odo", 32'(odometer), 3);
    chk("abort_late_ack", 32'(abort_ack), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
